// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int DEFAULT_ADDR_W   = 16;
    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_PC_STEP  = 4;
    localparam int DEFAULT_RESET_PC = 0;
    localparam int DEFAULT_DEPTH    = 2;

    // Opcode field of IR, shared with the controller decode.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO holding fetched words with their PC.
// The head is registered so it holds its last value once the FIFO drains.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count_next,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_pc
);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [CNT_W-1:0]  count_q;
    logic              pop_ok;
    logic [DATA_W-1:0] head_data_next;
    logic [ADDR_W-1:0] head_pc_next;

    assign pop_ok     = pop & (count_q != '0);
    assign head_valid = (count_q != '0);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    // Occupancy after this cycle's push/pop/flush; also drives the issue decision upstream.
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop_ok) begin
            count_next = count_q + CNT_W'(1);
        end else if (!push && pop_ok) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Next head: the entry behind the popped one, or a push landing in an empty FIFO.
    always_comb begin
        head_data_next = head_data;
        head_pc_next   = head_pc;
        if (!flush) begin
            if (pop_ok) begin
                if (count_q > CNT_W'(1)) begin
                    head_data_next = mem_data[rd_ptr_inc];
                    head_pc_next   = mem_pc[rd_ptr_inc];
                end else if (push) begin
                    head_data_next = push_data;
                    head_pc_next   = push_pc;
                end
            end else if (count_q == '0 && push) begin
                head_data_next = push_data;
                head_pc_next   = push_pc;
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_data[wr_ptr] <= push_data;
            mem_pc[wr_ptr]   <= push_pc;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            head_data <= '0;
            head_pc   <= '0;
        end else begin
            count_q   <= count_next;
            head_data <= head_data_next;
            head_pc   <= head_pc_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr_inc;
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one-at-a-time reads to instruction memory,
// buffers returned words with their PC, and handles controller redirects.
//
// state | meaning
// RUN   | normal fetch; a completed read is pushed into the buffer
// DRAIN | redirect arrived with a read in flight; that response is dropped,
//       | fetch_pc holds the redirect target until the read completes
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int PC_STEP  = DEFAULT_PC_STEP,
    parameter int RESET_PC = DEFAULT_RESET_PC,
    parameter int DEPTH    = DEFAULT_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_accept,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic              req_q;
    logic              req_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic              transfer;
    logic              pending;
    logic              push;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  count_next;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign transfer  = req_q & imem_ready;
    // A request still open after this cycle must keep req/addr stable.
    assign pending   = req_q & ~imem_ready;
    assign flush     = redirect;
    assign pop       = ir_accept & ir_valid & ~redirect;

    // Next state, next fetch PC and buffer push.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        push          = 1'b0;
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            state_next    = pending ? DRAIN : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (transfer) begin
                        push          = 1'b1;
                        fetch_pc_next = addr_q + ADDR_W'(PC_STEP);
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Issue decision: hold an open request, else issue when running with buffer room left.
    always_comb begin
        req_next  = 1'b0;
        addr_next = addr_q;
        if (pending) begin
            req_next = 1'b1;
        end else if (state_next == RUN && count_next < DEPTH_C) begin
            req_next  = 1'b1;
            addr_next = fetch_pc_next;
        end
    end

    // State, request and PC registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            req_q    <= 1'b0;
            addr_q   <= ADDR_W'(RESET_PC);
            fetch_pc <= ADDR_W'(RESET_PC);
        end else begin
            state    <= state_next;
            req_q    <= req_next;
            addr_q   <= addr_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (imem_rdata),
        .push_pc    (addr_q),
        .pop        (pop),
        .flush      (flush),
        .count_next (count_next),
        .head_valid (ir_valid),
        .head_data  (ir),
        .head_pc    (ir_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fixed stimulus with hand-computed expectations.
module tb_instr_fetch;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_accept;
    logic        redirect;
    logic [15:0] redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_accept   (ir_accept),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: word at address a is a ^ 0xA5A5.
    function automatic logic [15:0] memword(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    assign imem_rdata = memword(imem_addr);

    // A push into a full buffer must never happen.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(dut.push && dut.u_fifo.count_q == 2'd2))
                else $error("FAIL push_while_full");
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        ir_accept   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        check_eq("rst_req",    imem_req,  1'b0);
        check_eq("rst_addr",   imem_addr, 16'h0000);
        check_eq("rst_valid",  ir_valid,  1'b0);
        check_eq("rst_ir",     ir,        16'h0000);
        check_eq("rst_ir_pc",  ir_pc,     16'h0000);

        // Streaming: zero-wait memory, continuous accept.
        reset = 1'b0; imem_ready = 1'b1; ir_accept = 1'b1;
        tick();
        check_eq("t1_c1_req",   imem_req,  1'b1);
        check_eq("t1_c1_addr",  imem_addr, 16'h0000);
        check_eq("t1_c1_valid", ir_valid,  1'b0);
        tick();
        check_eq("t1_c2_addr",  imem_addr, 16'h0004);
        check_eq("t1_c2_valid", ir_valid,  1'b1);
        check_eq("t1_c2_pc",    ir_pc,     16'h0000);
        check_eq("t1_c2_ir",    ir,        memword(16'h0000));
        tick();
        check_eq("t1_c3_addr",  imem_addr, 16'h0008);
        check_eq("t1_c3_valid", ir_valid,  1'b1);
        check_eq("t1_c3_pc",    ir_pc,     16'h0004);
        check_eq("t1_c3_ir",    ir,        memword(16'h0004));

        // Back-pressure: buffer fills after two words, then request stops.
        reset = 1'b1; ir_accept = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_eq("t2_c1_addr",  imem_addr, 16'h0000);
        tick();
        check_eq("t2_c2_req",   imem_req,  1'b1);
        check_eq("t2_c2_addr",  imem_addr, 16'h0004);
        tick();
        check_eq("t2_c3_req",   imem_req,  1'b0);
        check_eq("t2_c3_valid", ir_valid,  1'b1);
        check_eq("t2_c3_ir",    ir,        memword(16'h0000));
        tick();
        check_eq("t2_c4_req",   imem_req,  1'b0);
        check_eq("t2_c4_pc",    ir_pc,     16'h0000);
        ir_accept = 1'b1;
        tick();
        check_eq("t2_c5_req",   imem_req,  1'b1);
        check_eq("t2_c5_addr",  imem_addr, 16'h0008);
        check_eq("t2_c5_pc",    ir_pc,     16'h0004);
        ir_accept = 1'b0; imem_ready = 1'b0;

        // Wait states: address held while ready is low, one push on completion.
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_ready = 1'b1; ir_accept = 1'b1;
        tick();
        tick();
        check_eq("t3_first_pc", ir_pc,     16'h0000);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_hold_req",  imem_req,  1'b1);
            check_eq("t3_hold_addr", imem_addr, 16'h0004);
        end
        imem_ready = 1'b1;
        tick();
        check_eq("t3_done_valid", ir_valid,  1'b1);
        check_eq("t3_done_pc",    ir_pc,     16'h0004);
        check_eq("t3_done_addr",  imem_addr, 16'h0008);
        imem_ready = 1'b0;
        tick();
        check_eq("t3_no_dup",     ir_valid,  1'b0);
        check_eq("t3_out_addr",   imem_addr, 16'h0008);

        // Redirect with a request in flight: drain, drop, refetch at target.
        redirect = 1'b1; redirect_pc = 16'h0100; ir_accept = 1'b0;
        tick();
        redirect = 1'b0;
        check_eq("t4_drain_req",   imem_req,  1'b1);
        check_eq("t4_drain_addr",  imem_addr, 16'h0008);
        check_eq("t4_drain_valid", ir_valid,  1'b0);
        tick();
        check_eq("t4_drain2_addr", imem_addr, 16'h0008);
        imem_ready = 1'b1;
        tick();
        check_eq("t4_drop_valid",  ir_valid,  1'b0);
        check_eq("t4_new_req",     imem_req,  1'b1);
        check_eq("t4_new_addr",    imem_addr, 16'h0100);
        tick();
        check_eq("t4_first_valid", ir_valid,  1'b1);
        check_eq("t4_first_pc",    ir_pc,     16'h0100);
        check_eq("t4_first_ir",    ir,        memword(16'h0100));

        // Redirect coinciding with ready and accept.
        ir_accept = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check_eq("t5_flush_valid", ir_valid,  1'b0);
        check_eq("t5_ir_hold",     ir,        memword(16'h0100));
        check_eq("t5_req",         imem_req,  1'b1);
        check_eq("t5_addr",        imem_addr, 16'h0040);
        tick();
        check_eq("t5_pc",          ir_pc,     16'h0040);
        check_eq("t5_next_addr",   imem_addr, 16'h0044);

        // Address wrap at the top of memory.
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        check_eq("t6_top_addr",    imem_addr, 16'hFFFC);
        tick();
        check_eq("t6_wrap_addr",   imem_addr, 16'h0000);
        check_eq("t6_top_pc",      ir_pc,     16'hFFFC);
        check_eq("t6_top_ir",      ir,        memword(16'hFFFC));
        tick();
        check_eq("t6_zero_pc",     ir_pc,     16'h0000);
        check_eq("t6_step_addr",   imem_addr, 16'h0004);

        // Redirect overwrite while draining.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        check_eq("t6_drain_addr",  imem_addr, 16'h0004);
        redirect_pc = 16'h0300;
        tick();
        redirect = 1'b0; imem_ready = 1'b1;
        tick();
        check_eq("t6_ovr_addr",    imem_addr, 16'h0300);
        check_eq("t6_ovr_valid",   ir_valid,  1'b0);

        // Reset in the middle of a drain.
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0500;
        tick();
        check_eq("t6_drain2_addr", imem_addr, 16'h0300);
        reset = 1'b1; redirect = 1'b0;
        tick();
        check_eq("t6_rst_req",     imem_req,  1'b0);
        check_eq("t6_rst_addr",    imem_addr, 16'h0000);
        check_eq("t6_rst_valid",   ir_valid,  1'b0);
        check_eq("t6_rst_ir",      ir,        16'h0000);
        check_eq("t6_rst_pc",      ir_pc,     16'h0000);
        reset = 1'b0; imem_ready = 1'b1;
        tick();
        check_eq("t6_restart_req",  imem_req,  1'b1);
        check_eq("t6_restart_addr", imem_addr, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the single-cycle controller.
- Holds the fetch PC and issues 16-bit instruction reads to instruction memory with a req/ready handshake.
- Buffers returned words with their PC in a small FIFO and presents the head as IR to the controller.
- Accepts PC redirects (taken branch, call, return from M[SP]) from the controller and flushes stale instructions.

Parameters:
ADDR_W, 16, width of PC and instruction memory address
DATA_W, 16, instruction width (IR[15:0])
PC_STEP, 4, sequential PC increment (matches controller PC+4 path)
RESET_PC, 0, first fetch address after reset
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  read address; stable while imem_req high and imem_ready low
imem_ready  in  1  response valid this cycle; completes the request (may be high in the same cycle req rises)
imem_rdata  in  DATA_W  instruction word, valid when imem_req & imem_ready
ir_valid  out  1  FIFO head valid
ir  out  DATA_W  FIFO head instruction (to controller IR)
ir_pc  out  ADDR_W  PC of head instruction (for PC+4 / PC+4+Label)
ir_accept  in  1  controller consumes head this cycle (ignored when ir_valid=0)
redirect  in  1  load new fetch PC, flush buffer
redirect_pc  in  ADDR_W  new fetch PC; used as-is, no alignment

Behaviour:
- Reset (sync, priority over everything): imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO count=0, ir_valid=0, ir=0, ir_pc=0, state=RUN.
- imem_req and imem_addr are registered. First request rises in the first cycle after reset deasserts, with addr=RESET_PC.
- Handshake:
  - At most one outstanding request.
  - Once raised, req and addr hold until the cycle with imem_ready=1.
  - Transfer occurs on req & ready.
- States:
  - RUN: push imem_rdata/imem_addr into the FIFO on transfer. fetch_pc <= imem_addr + PC_STEP, modulo 2^ADDR_W, wrapping 0xFFFC -> 0x0000.
  - DRAIN: a redirect arrived with a request in flight. req/addr are held. The response is discarded (no push). On ready: go to RUN, and the next request goes to the saved redirect_pc.
- Issue rule:
  - next-cycle req = 1 iff state_next=RUN, no request remains outstanding, and count_next < DEPTH.
  - count_next includes this cycle's push and pop.
  - Zero-wait memory with continuous ir_accept gives one instruction per cycle.
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - A push while full cannot occur by construction; the bench asserts this.
  - ir/ir_pc are driven from head storage. When empty, they hold their last values (0 after reset).
- Redirect (highest priority after reset):
  - Flushes FIFO (count=0, ir_valid=0 next cycle); ir_accept that cycle is ignored.
  - No request outstanding: next cycle req=1, addr=redirect_pc.
  - Request outstanding, ready=0: enter DRAIN and save redirect_pc.
  - Request outstanding, ready=1 same cycle: data discarded, next cycle req=1 with addr=redirect_pc (no DRAIN).
  - Redirect while in DRAIN: saved PC is overwritten by the newest redirect_pc.
- Latency: transfer in cycle t -> ir_valid=1 with that word in cycle t+1.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e {RUN, DRAIN}
  - default constants PC_STEP, RESET_PC
  - opcode field position IR[15:11], shared with the controller
- Sub-module fetch_fifo: DEPTH x (DATA_W+ADDR_W) register FIFO with push/pop/flush, count, head outputs.

Test Plan:
1. Reset, ready tied 1, accept tied 1 -> req at cycle 1 addr 0x0000. Addresses 0x0000, 0x0004, 0x0008 on consecutive cycles. ir_valid from cycle 2, ir_pc tracks each address one cycle later.
2. accept=0, ready=1 -> exactly 2 transfers (0x0000, 0x0004), then req=0. count=2, ir=word@0x0000. Raise accept for one cycle -> req returns next cycle with addr 0x0008.
3. ready held 0 for 3 cycles -> addr 0x0004 stable and req high throughout. Ready on 4th cycle -> single push, no duplicate.
4. Request to 0x0008 outstanding, redirect to 0x0100, ready arrives 2 cycles later -> response dropped, ir_valid=0. Next req addr 0x0100, and the first ir_pc after that is 0x0100.
5. redirect=1, redirect_pc=0x0040 in the same cycle as ready and ir_accept -> no push, FIFO empty next cycle, next req addr 0x0040.
6. redirect_pc=0xFFFC, ready=1 -> fetched addresses 0xFFFC then 0x0000. Assert reset mid-DRAIN -> all outputs at reset values next cycle, req to RESET_PC the cycle after.
